dac_slew_ctrl: RTL and testbench

Two-channel DAC output sequencer for the 14-bit dual-channel DAC output stage. It sits in the `dac_clk_1x` domain, directly upstream of the DAC output block's signed channel-data inputs. It gates DAC data until the DAC clock is locked and settled. It slew-limits both channels toward software-set targets and ramps both channels back to zero before shutdown, so the analog outputs never jump on enable or disable.

---
 rtl/dac_slew_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_dac_slew_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_slew_ctrl.sv
// dac_slew_ctrl: two-channel DAC output sequencer in the dac_clk_1x domain.
// Holds both DAC channels at zero until the DAC clock has been locked and
// enabled for SETTLE_CYCLES cycles. Slew-limits each channel toward its target,
// and ramps both channels back to zero before returning to OFF.
//
// Ports:
//   dac_clk_1x              DAC word clock (only clock)
//   dac_rst                 synchronous active-high reset
//   dac_locked              DAC clock PLL lock
//   enable                  level request for outputs on
//   target_valid            one-cycle pulse, loads target_a/target_b
//   target_a, target_b      signed channel targets
//   step                    unsigned max change per cycle, 0 = unlimited
//   dac_dat_a_o/_b_o        registered signed channel data
//   state_o                 0=OFF 1=SETTLE 2=RUN 3=SHUTDOWN
//   at_target               RUN and both channels equal their targets
//   busy                    SETTLE/SHUTDOWN, or RUN and not at target
`timescale 1ns/1ps
module dac_slew_ctrl #(
    parameter int unsigned DW            = 14,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic                 dac_clk_1x,
    input  logic                 dac_rst,
    input  logic                 dac_locked,
    input  logic                 enable,
    input  logic                 target_valid,
    input  logic signed [DW-1:0] target_a,
    input  logic signed [DW-1:0] target_b,
    input  logic        [DW-1:0] step,
    output logic signed [DW-1:0] dac_dat_a_o,
    output logic signed [DW-1:0] dac_dat_b_o,
    output logic        [1:0]    state_o,
    output logic                 at_target,
    output logic                 busy
);

    localparam int unsigned   CW       = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_SHUT   = 2'd3
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic signed [DW-1:0]  r_cur_a, r_cur_b;
    logic signed [DW-1:0]  r_tgt_a, r_tgt_b;
    logic                  r_at_target;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic signed [DW-1:0]  w_cur_a_nxt, w_cur_b_nxt;
    logic signed [DW-1:0]  w_tgt_a_nxt, w_tgt_b_nxt;
    logic signed [DW-1:0]  w_tgt_a_eff, w_tgt_b_eff;
    logic                  w_at_nxt;
    logic                  w_busy_nxt;

    // One slew step of cur toward tgt; the difference is taken one bit wider so
    // full-scale moves neither overflow nor overshoot.
    function automatic logic signed [DW-1:0] slew(
        input logic signed [DW-1:0] cur,
        input logic signed [DW-1:0] tgt,
        input logic        [DW-1:0] stp
    );
        logic [DW:0] cur_x;
        logic [DW:0] tgt_x;
        logic [DW:0] diff;
        logic [DW:0] mag;
        logic [DW:0] stp_x;
        logic [DW:0] moved;
        cur_x = {cur[DW-1], cur};
        tgt_x = {tgt[DW-1], tgt};
        diff  = tgt_x - cur_x;
        mag   = diff[DW] ? (~diff + (DW+1)'(1)) : diff;
        stp_x = {1'b0, stp};
        if (stp == '0 || mag <= stp_x) begin
            return tgt;
        end
        moved = diff[DW] ? (cur_x - stp_x) : (cur_x + stp_x);
        return DW'(moved);
    endfunction

    // A target arriving this cycle takes effect in this cycle's slew.
    always_comb begin
        w_tgt_a_eff = target_valid ? target_a : r_tgt_a;
        w_tgt_b_eff = target_valid ? target_b : r_tgt_b;
    end

    // Next-state, slew and status logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_a_nxt = r_cur_a;
        w_cur_b_nxt = r_cur_b;
        w_tgt_a_nxt = r_tgt_a;
        w_tgt_b_nxt = r_tgt_b;

        case (r_state)
            ST_OFF: begin
                w_cnt_nxt   = '0;
                w_cur_a_nxt = '0;
                w_cur_b_nxt = '0;
                w_tgt_a_nxt = '0;
                w_tgt_b_nxt = '0;
                if (enable && dac_locked) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!dac_locked || !enable) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                    w_tgt_a_nxt = '0;
                    w_tgt_b_nxt = '0;
                end else begin
                    if (target_valid) begin
                        w_tgt_a_nxt = target_a;
                        w_tgt_b_nxt = target_b;
                    end
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!dac_locked) begin
                    // Clock invalid: drop to zero with no ramp.
                    w_state_nxt = ST_OFF;
                    w_cur_a_nxt = '0;
                    w_cur_b_nxt = '0;
                    w_tgt_a_nxt = '0;
                    w_tgt_b_nxt = '0;
                end else if (!enable) begin
                    // Pending target is discarded on the way into shutdown.
                    w_state_nxt = ST_SHUT;
                    w_cur_a_nxt = slew(r_cur_a, r_tgt_a, step);
                    w_cur_b_nxt = slew(r_cur_b, r_tgt_b, step);
                    w_tgt_a_nxt = '0;
                    w_tgt_b_nxt = '0;
                end else begin
                    w_tgt_a_nxt = w_tgt_a_eff;
                    w_tgt_b_nxt = w_tgt_b_eff;
                    w_cur_a_nxt = slew(r_cur_a, w_tgt_a_eff, step);
                    w_cur_b_nxt = slew(r_cur_b, w_tgt_b_eff, step);
                end
            end
            ST_SHUT: begin
                if (!dac_locked) begin
                    w_state_nxt = ST_OFF;
                    w_cur_a_nxt = '0;
                    w_cur_b_nxt = '0;
                end else if (r_cur_a == '0 && r_cur_b == '0) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cur_a_nxt = slew(r_cur_a, '0, step);
                    w_cur_b_nxt = slew(r_cur_b, '0, step);
                end
                w_tgt_a_nxt = '0;
                w_tgt_b_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = '0;
                w_cur_a_nxt = '0;
                w_cur_b_nxt = '0;
                w_tgt_a_nxt = '0;
                w_tgt_b_nxt = '0;
            end
        endcase

        // Status is computed from next-cycle values so it lines up with the outputs.
        w_at_nxt   = (w_state_nxt == ST_RUN) &&
                     (w_cur_a_nxt == w_tgt_a_nxt) && (w_cur_b_nxt == w_tgt_b_nxt);
        w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SHUT) ||
                     ((w_state_nxt == ST_RUN) && !w_at_nxt);
    end

    // State and datapath registers.
    always_ff @(posedge dac_clk_1x) begin
        if (dac_rst) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            r_cur_a     <= '0;
            r_cur_b     <= '0;
            r_tgt_a     <= '0;
            r_tgt_b     <= '0;
            r_at_target <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cur_a     <= w_cur_a_nxt;
            r_cur_b     <= w_cur_b_nxt;
            r_tgt_a     <= w_tgt_a_nxt;
            r_tgt_b     <= w_tgt_b_nxt;
            r_at_target <= w_at_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign dac_dat_a_o = r_cur_a;
    assign dac_dat_b_o = r_cur_b;
    assign state_o     = r_state;
    assign at_target   = r_at_target;
    assign busy        = r_busy;

endmodule

// File: tb/tb_dac_slew_ctrl.sv
// Testbench for dac_slew_ctrl: directed stimulus pushes expected per-cycle
// outputs into a queue; a monitor compares them on the falling edge.
`timescale 1ns/1ps
module tb_dac_slew_ctrl;

    localparam int unsigned DW = 14;
    localparam int unsigned SC = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 locked;
    logic                 en;
    logic                 tv;
    logic signed [DW-1:0] ta;
    logic signed [DW-1:0] tbv;
    logic        [DW-1:0] stp;
    logic signed [DW-1:0] dat_a;
    logic signed [DW-1:0] dat_b;
    logic        [1:0]    st;
    logic                 at_t;
    logic                 bsy;

    dac_slew_ctrl #(.DW(DW), .SETTLE_CYCLES(SC)) dut (
        .dac_clk_1x  (clk),
        .dac_rst     (rst),
        .dac_locked  (locked),
        .enable      (en),
        .target_valid(tv),
        .target_a    (ta),
        .target_b    (tbv),
        .step        (stp),
        .dac_dat_a_o (dat_a),
        .dac_dat_b_o (dat_b),
        .state_o     (st),
        .at_target   (at_t),
        .busy        (bsy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    a;
        int    b;
        int    s;
        int    at;
        int    bz;
        string tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string tag, input string fld, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s cycle=%0d actual=%0d required=%0d", tag, fld, cyc, act, req);
        end
    endfunction

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                chk(q[i].tag, "a",     int'(dat_a), q[i].a);
                chk(q[i].tag, "b",     int'(dat_b), q[i].b);
                chk(q[i].tag, "state", int'(st),    q[i].s);
                chk(q[i].tag, "at",    int'(at_t),  q[i].at);
                chk(q[i].tag, "busy",  int'(bsy),   q[i].bz);
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int d, input int a, input int b, input int s,
                             input int at, input int bz, input string tag);
        exp_t e;
        e.cyc = cyc + d;
        e.a   = a;
        e.b   = b;
        e.s   = s;
        e.at  = at;
        e.bz  = bz;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input int a, input int b, input int s);
        ta  = DW'(a);
        tbv = DW'(b);
        stp = DW'(s);
        tv  = 1'b1;
        tick();
        tv  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; locked = 1'b1; en = 1'b0; tv = 1'b0;
        ta = '0; tbv = '0; stp = '0;
        repeat (2) tick();
        expect_at(1, 0, 0, 0, 0, 0, "reset");
        tick();
        rst = 1'b0;
        expect_at(1, 0, 0, 0, 0, 0, "idle_off");
        tick();

        // Power-up: enable at cycle 0, target pulsed during SETTLE, step 0.
        en = 1'b1;
        for (int d = 1; d <= 16; d++) expect_at(d, 0, 0, 1, 0, 1, "pu_settle");
        expect_at(17, 0, 0, 2, 0, 1, "pu_run_entry");
        expect_at(18, 1000, -1000, 2, 1, 0, "pu_first");
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 5) begin
                tv = 1'b1; ta = 14'sd1000; tbv = -14'sd1000;
            end else begin
                tv = 1'b0;
            end
        end

        // Slew from 0/0 with step 100 toward 1050/-250.
        expect_at(1, 0, 0, 2, 1, 0, "slew_zero");
        pulse(0, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            expect_at(k, (k == 11) ? 1050 : 100 * k, (k >= 3) ? -250 : -100 * k,
                      2, (k == 11) ? 1 : 0, (k == 11) ? 0 : 1, "slew");
        end
        pulse(1050, -250, 100);
        repeat (10) tick();

        // Full-scale moves.
        expect_at(1, -8192, 8191, 2, 1, 0, "ext_load");
        pulse(-8192, 8191, 0);
        expect_at(1, 8191, -8192, 2, 1, 0, "ext_jump");
        pulse(8191, -8192, 16383);
        expect_at(1, -8191, 8190, 2, 0, 1, "ext_step1");
        expect_at(2, -8192, 8191, 2, 1, 0, "ext_step2");
        pulse(-8192, 8191, 16382);
        tick();

        // Shutdown ramp; same-cycle and in-shutdown target pulses are discarded.
        expect_at(1, 500, -300, 2, 1, 0, "sd_pre");
        pulse(500, -300, 0);
        en = 1'b0; stp = 14'd200; tv = 1'b1; ta = 14'sd7; tbv = 14'sd7;
        expect_at(1, 500, -300, 3, 0, 1, "sd_entry");
        expect_at(2, 300, -100, 3, 0, 1, "sd_ramp1");
        expect_at(3, 100, 0, 3, 0, 1, "sd_ramp2");
        expect_at(4, 0, 0, 3, 0, 1, "sd_zero");
        expect_at(5, 0, 0, 0, 0, 0, "sd_off");
        tick(); tv = 1'b0;
        tick(); tv = 1'b1; ta = 14'sd4000; tbv = 14'sd4000;
        tick(); tv = 1'b0;
        tick();
        tick();

        // Lock loss mid-slew, stay OFF while unlocked, full SETTLE after relock.
        en = 1'b1;
        for (int d = 1; d <= 16; d++) expect_at(d, 0, 0, 1, 0, 1, "ll_settle");
        expect_at(17, 0, 0, 2, 0, 1, "ll_run_entry");
        expect_at(18, 200, -200, 2, 0, 1, "ll_slew1");
        expect_at(19, 400, -400, 2, 0, 1, "ll_slew2");
        expect_at(20, 0, 0, 0, 0, 0, "ll_off");
        expect_at(21, 0, 0, 0, 0, 0, "ll_hold1");
        expect_at(22, 0, 0, 0, 0, 0, "ll_hold2");
        for (int d = 23; d <= 38; d++) expect_at(d, 0, 0, 1, 0, 1, "ll_resettle");
        expect_at(39, 0, 0, 2, 1, 0, "ll_run_cleared");
        for (int i = 1; i <= 39; i++) begin
            tick();
            if (i == 2) begin
                tv = 1'b1; ta = 14'sd2000; tbv = -14'sd2000;
            end else begin
                tv = 1'b0;
            end
            if (i == 19) locked = 1'b0;
            if (i == 22) locked = 1'b1;
        end

        // Re-enable while ramping down: finish ramp, one OFF cycle, then SETTLE.
        expect_at(1, 300, -300, 2, 1, 0, "re_pre");
        pulse(300, -300, 0);
        en = 1'b0; stp = 14'd100;
        expect_at(1, 300, -300, 3, 0, 1, "re_sd_entry");
        tick();
        en = 1'b1;
        expect_at(1, 200, -200, 3, 0, 1, "re_ramp1");
        expect_at(2, 100, -100, 3, 0, 1, "re_ramp2");
        expect_at(3, 0, 0, 3, 0, 1, "re_zero");
        expect_at(4, 0, 0, 0, 0, 0, "re_off");
        for (int d = 5; d <= 20; d++) expect_at(d, 0, 0, 1, 0, 1, "re_settle");
        expect_at(21, 0, 0, 2, 1, 0, "re_run_cleared");
        expect_at(22, 0, 0, 2, 1, 0, "re_run_hold");
        repeat (22) tick();
        expect_at(1, 50, 60, 2, 1, 0, "re_new_target");
        pulse(50, 60, 0);

        // Mid-operation reset, restart, then enable dropped during SETTLE.
        rst = 1'b1;
        expect_at(1, 0, 0, 0, 0, 0, "mid_reset");
        tick();
        rst = 1'b0;
        expect_at(1, 0, 0, 1, 0, 1, "post_reset_settle");
        tick();
        en = 1'b0;
        expect_at(1, 0, 0, 0, 0, 0, "settle_abort");
        tick();

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0 pending", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
